// File: rtl/checksum_sequencer_if.sv
// ID stream handshake between the loader and the checksum sequencer.
// One 26-byte box ID per accepted beat; id_last closes a run.
interface checksum_sequencer_if;
  logic         id_valid;
  logic         id_ready;
  logic [207:0] id_data;
  logic         id_last;

  modport master (
    output id_valid,
    output id_data,
    output id_last,
    input  id_ready
  );

  modport slave (
    input  id_valid,
    input  id_data,
    input  id_last,
    output id_ready
  );
endinterface

// File: rtl/checksum_sequencer.sv
// Box-ID checksum: counts pair/triplet IDs, then multiplies the two
// counts with a CNT_W-cycle shift-add once the final ID has drained.
module id_checker (
  input  logic [207:0] id,
  output logic         pair,
  output logic         triplet
);
  always_comb begin
    logic [4:0] cnt;
    pair    = 1'b0;
    triplet = 1'b0;
    cnt     = '0;
    for (int k = 0; k < 26; k++) begin
      cnt = '0;
      for (int i = 0; i < 26; i++) begin
        if (id[8*i +: 8] == 8'(97 + k)) begin
          cnt = cnt + 5'd1;
        end
      end
      if (cnt == 5'd2) pair    = 1'b1;
      if (cnt == 5'd3) triplet = 1'b1;
    end
  end
endmodule

module checksum_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  checksum_sequencer_if.slave  id,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     pair_count,
  output logic [CNT_W-1:0]     triplet_count,
  output logic [2*CNT_W-1:0]   checksum,
  output logic                 overflow
);
  localparam int PW = 2 * CNT_W;
  localparam int IW = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    DRAIN,
    MULT,
    DONE
  } state_t;

  state_t          state, nxt;
  logic [207:0]    id_q;
  logic            vld_q;
  logic [IW-1:0]   bit_idx;
  logic            pair_hit, trip_hit;
  logic            acc, clr, last_bit;

  id_checker u_id_checker (
    .id      (id_q),
    .pair    (pair_hit),
    .triplet (trip_hit)
  );

  assign acc      = (state == ACCEPT) && id.id_valid;
  assign clr      = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (bit_idx == IW'(CNT_W - 1));
  assign id.id_ready = (state == ACCEPT);
  assign busy = (state == ACCEPT) || (state == DRAIN) || (state == MULT);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = ACCEPT;
      ACCEPT:  if (id.id_valid && id.id_last) nxt = DRAIN;
      DRAIN:   nxt = MULT;
      MULT:    if (last_bit) nxt = DONE;
      DONE:    if (start) nxt = ACCEPT;
      default: nxt = IDLE;
    endcase
  end

  // Multiplier bits are read straight from triplet_count, so MULT
  // needs no operand load cycle after the final count lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q          <= '0;
      vld_q         <= 1'b0;
      pair_count    <= '0;
      triplet_count <= '0;
      checksum      <= '0;
      overflow      <= 1'b0;
      bit_idx       <= '0;
      done          <= 1'b0;
    end else begin
      vld_q <= acc;
      if (acc) id_q <= id.id_data;
      if (clr) begin
        pair_count    <= '0;
        triplet_count <= '0;
        checksum      <= '0;
        overflow      <= 1'b0;
        bit_idx       <= '0;
      end else begin
        if (vld_q && pair_hit) begin
          if (&pair_count) overflow   <= 1'b1;
          else             pair_count <= pair_count + 1'b1;
        end
        if (vld_q && trip_hit) begin
          if (&triplet_count) overflow      <= 1'b1;
          else                triplet_count <= triplet_count + 1'b1;
        end
        if (state == MULT) begin
          if (triplet_count[bit_idx]) begin
            checksum <= checksum + (PW'(pair_count) << bit_idx);
          end
          bit_idx <= bit_idx + 1'b1;
        end
      end
      done <= (state == DONE) && !start;
    end
  end
endmodule

// File: tb/tb_checksum_sequencer.sv
// Randomized bench for checksum_sequencer against a letter-count
// reference model; CNT_W=4 so saturation is reachable quickly.
module tb_checksum_sequencer;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, overflow;
  logic [CW-1:0]   pc, tc;
  logic [2*CW-1:0] cs;

  checksum_sequencer_if bus ();

  checksum_sequencer #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .id            (bus),
    .busy          (busy),
    .done          (done),
    .pair_count    (pc),
    .triplet_count (tc),
    .checksum      (cs),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int npass = 0;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    nchk++;
    if (got == exp) npass++;
    else $display("FAIL %s got %0d exp %0d", tag, got, exp);
  endtask

  function automatic logic [207:0] s2id(input string s);
    logic [207:0] v;
    v = '0;
    for (int i = 0; i < 26; i++) v[8*i +: 8] = s[i];
    return v;
  endfunction

  function automatic logic [207:0] rand_id();
    logic [207:0] v;
    int span;
    span = $urandom_range(8, 26);
    for (int i = 0; i < 26; i++)
      v[8*i +: 8] = 8'(97 + $urandom_range(0, span - 1));
    return v;
  endfunction

  function automatic void flags(input logic [207:0] v,
                                output bit p, output bit t);
    int cnt[26];
    int b;
    foreach (cnt[k]) cnt[k] = 0;
    for (int i = 0; i < 26; i++) begin
      b = int'(v[8*i +: 8]);
      if (b >= 97 && b <= 122) cnt[b - 97]++;
    end
    p = 0;
    t = 0;
    foreach (cnt[k]) begin
      if (cnt[k] == 2) p = 1;
      if (cnt[k] == 3) t = 1;
    end
  endfunction

  task automatic run(input string tag, input logic [207:0] ids[$],
                     input int gap, input bit noise);
    int  p, t, lat;
    bit  ov, fp, ft;
    p = 0; t = 0; ov = 0;
    foreach (ids[i]) begin
      flags(ids[i], fp, ft);
      if (fp) begin if (p == MAXC) ov = 1; else p++; end
      if (ft) begin if (t == MAXC) ov = 1; else t++; end
    end

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy0"}, busy, 1);
    chk({tag, ".done0"}, done, 0);
    chk({tag, ".pc0"}, pc, 0);
    chk({tag, ".tc0"}, tc, 0);
    chk({tag, ".cs0"}, cs, 0);
    chk({tag, ".ov0"}, overflow, 0);

    foreach (ids[i]) begin
      chk({tag, ".ready"}, bus.id_ready, 1);
      bus.id_valid = 1'b1;
      bus.id_data  = ids[i];
      bus.id_last  = (i == ids.size() - 1);
      @(posedge clk); #1;
      bus.id_valid = 1'b0;
      bus.id_last  = 1'b0;
      if (i != ids.size() - 1) begin
        repeat (gap) begin
          bus.id_last = noise;
          @(posedge clk); #1;
        end
        bus.id_last = 1'b0;
      end
    end
    chk({tag, ".nready"}, bus.id_ready, 0);

    lat = 0;
    while (!done && lat < 100) begin
      if (noise && lat < CW) begin
        bus.id_valid = 1'b1;
        bus.id_data  = rand_id();
        bus.id_last  = 1'b1;
      end else begin
        bus.id_valid = 1'b0;
        bus.id_last  = 1'b0;
      end
      start = noise && (lat == 2);
      @(posedge clk); #1;
      lat++;
    end
    bus.id_valid = 1'b0;
    bus.id_last  = 1'b0;
    start = 1'b0;

    chk({tag, ".lat"}, lat, CW + 2);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".pc"}, pc, p);
    chk({tag, ".tc"}, tc, t);
    chk({tag, ".cs"}, cs, p * t);
    chk({tag, ".ov"}, overflow, ov);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, ".hold"}, done, 1);
    chk({tag, ".cshold"}, cs, p * t);
  endtask

  initial begin
    logic [207:0] id1, id2;
    logic [207:0] q[$];

    bus.id_valid = 1'b0;
    bus.id_last  = 1'b0;
    bus.id_data  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", bus.id_ready, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.ov", overflow, 0);
    chk("rst.pc", pc, 0);
    chk("rst.tc", tc, 0);
    chk("rst.cs", cs, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle.busy", busy, 0);

    id1 = s2id("wlpiogsvdfecjdqmnxakudrhbz");
    id2 = s2id("wbpiogsvdfecjdqmnxakudrhbz");

    q = {id1, id2};
    run("t2", q, 0, 0);
    run("t3", q, 3, 1);

    q = {};
    repeat (17) q.push_back(id2);
    run("t4", q, 0, 0);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.id_valid = 1'b1;
    bus.id_data  = id2;
    bus.id_last  = 1'b1;
    @(posedge clk); #1;
    bus.id_valid = 1'b0;
    bus.id_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5.busy", busy, 0);
    chk("t5.done", done, 0);
    chk("t5.pc", pc, 0);
    chk("t5.tc", tc, 0);
    chk("t5.cs", cs, 0);
    chk("t5.ov", overflow, 0);
    q = {id1};
    run("t5", q, 0, 0);

    q = {id2, id2, id2};
    run("t6a", q, 1, 0);
    q = {id1};
    run("t6b", q, 0, 0);

    for (int r = 0; r < 20; r++) begin
      int n;
      q = {};
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) q.push_back(rand_id());
      run($sformatf("rnd%0d", r), q, $urandom_range(0, 2),
          bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
